r_seq_ctrl: RTL
===============

Name: r_seq_ctrl

Overview:
Multi-cycle sequencer for the R-type execution datapath: register file, ALU and instruction memory.
- Fetches a 32-bit instruction over a request/valid handshake and decodes OP/func into the 3-bit ALU opcode.
- Steps the register-file read, ALU execute and writeback phases, then advances the PC.
- Traps on illegal instructions and on fetch timeout.
- Sits between instruction memory and the register file/ALU pair; the datapath itself holds no sequencing logic.

Parameters:
- PC_W, 32, PC / instruction address width.
- RESET_PC, 0, PC value after reset.
- FETCH_TMO, 15, maximum cycles waiting on imem_valid before trap (4-bit counter sufficient at default).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- run  in  1  level; 1 = execute continuously, 0 = stop at next instruction boundary.
- trap_clr  in  1  one-cycle pulse; leaves TRAP.
- imem_req  out  1  fetch request, held until accepted.
- imem_addr  out  PC_W  fetch address, equals pc.
- imem_valid  in  1  instruction data valid (one-cycle pulse).
- imem_data  in  32  instruction word.
- rf_ra1  out  5  rs field.
- rf_ra2  out  5  rt field.
- rf_wa  out  5  rd field.
- op_ld  out  1  pulse; datapath latches A/B operands.
- alu_op  out  3  ALU opcode.
- res_ld  out  1  pulse; datapath latches ALU result.
- rf_we  out  1  pulse; register-file write enable.
- pc  out  PC_W  current PC.
- busy  out  1  1 in any state except IDLE and TRAP.
- trap  out  1  1 in TRAP.
- trap_cause  out  2  00 none, 01 illegal, 10 fetch timeout.
- retired  out  16  count of completed instructions, wraps 0xFFFF -> 0.

Behaviour:
- Reset (async, rst_n=0) values:
  - state=IDLE, pc=RESET_PC, ir=0.
  - All pulse outputs 0; imem_req=0; alu_op=000; trap=0; trap_cause=00; retired=0.
- Decode, when OP==000000:
  - func 100000 add -> 100.
  - func 100010 sub -> 101.
  - func 100100 and -> 000.
  - func 100101 or -> 001.
  - func 100110 xor -> 010.
  - func 100111 nor -> 011.
  - func 101011 sltu -> 110.
  - func 000100 sllv -> 111.
- Decode, anything else:
  - ir==32'h0 is NOP: no rf_we, still retires.
  - Any other OP or func is illegal.
- States and transitions:
  - IDLE: run=1 -> FETCH.
  - FETCH: imem_req=1.
    - imem_valid=1 -> latch ir, -> DECODE.
    - Timeout counter reaching FETCH_TMO with no valid -> TRAP, cause 10.
  - DECODE: illegal -> TRAP, cause 01. NOP -> NEXT. Else -> READ.
  - READ: rf_ra1/rf_ra2 driven from ir; op_ld=1 for one cycle; -> EXEC.
  - EXEC: alu_op driven; res_ld=1 for one cycle; -> WB.
  - WB: rf_we=1 only if rd!=0; -> NEXT.
  - NEXT: pc<=pc+4 (wraps modulo 2^PC_W); retired+1. run=1 -> FETCH, else -> IDLE.
  - TRAP: pc frozen, no pulses, ignores run. trap_clr=1 -> IDLE, trap_cause=00; pc is not advanced.
- Output stability:
  - rf_ra1, rf_ra2, rf_wa and alu_op are registered from ir.
  - They stay stable from READ through WB.
  - They hold their last value in other states.
- Latency:
  - Legal ALU instruction: 5 cycles plus fetch wait, measured FETCH-entry to next FETCH-entry.
  - With imem_valid on the first FETCH cycle, that is 5 cycles total.
  - NOP: 3 cycles.
- run deasserted mid-instruction: the current instruction completes, then the block goes to IDLE.
- imem_valid outside FETCH is ignored.
- Reset mid-instruction aborts immediately; no partial rf_we.
- Fetch timeout counter clears on entry to FETCH.

Decomposition:
- Shared package holds:
  - state enum.
  - OP_RTYPE constant.
  - func code constants.
  - ALU_OP encodings.
  - trap cause codes.
- Sub-module r_func_dec, combinational, {OP, func} -> {alu_op, legal, nop}. Reusable by the existing decoder path.

Test Plan:
- Reset then run=1, imem returns 0x00221820 (add r3,r1,r2) on first FETCH cycle:
  - alu_op=100, rf_ra1=1, rf_ra2=2, rf_wa=3.
  - rf_we one pulse in WB.
  - pc=4, retired=1 after 5 cycles.
- Stream of eight instructions, one per func code:
  - alu_op sequence 100,101,000,001,010,011,110,111.
  - pc=0x20, retired=8.
- Instruction with rd=0 (0x00220020):
  - op_ld and res_ld pulse, no rf_we.
  - retired increments.
- ir=0x00000000 NOP: no op_ld/res_ld/rf_we, pc+4, 3-cycle instruction.
- Illegal instruction 0x8C220000 (lw):
  - trap=1, cause=01, pc unchanged.
  - trap_clr -> IDLE, cause=00.
- Fetch stall: imem_valid withheld 16 cycles -> trap with cause=10.
- Reset asserted during EXEC -> all outputs return to reset values the same cycle.
- run dropped during READ -> instruction completes, IDLE, busy=0.

Source files
------------

// File: rtl/r_seq_ctrl_pkg.sv
// Shared definitions for the R-type sequencer: FSM state encoding, the
// R-type opcode, func codes, ALU opcode encodings and trap cause codes.
package r_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_READ,
        ST_EXEC,
        ST_WB,
        ST_NEXT,
        ST_TRAP
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLTU = 6'b101011;
    localparam logic [5:0] FN_SLLV = 6'b000100;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_XOR  = 3'b010;
    localparam logic [2:0] ALU_NOR  = 3'b011;
    localparam logic [2:0] ALU_ADD  = 3'b100;
    localparam logic [2:0] ALU_SUB  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;
    localparam logic [2:0] ALU_SLLV = 3'b111;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_FTMO    = 2'b10;

endpackage

// File: rtl/r_seq_ctrl_if.sv
// Instruction-memory fetch bus.
//   imem_req   : fetch request, held until imem_valid is seen
//   imem_addr  : fetch address
//   imem_valid : one-cycle pulse, imem_data is valid
//   imem_data  : 32-bit instruction word
// master = sequencer side, slave = instruction memory side.
interface r_seq_ctrl_if #(
    parameter int PC_W = 32
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_valid;
    logic [31:0]     imem_data;

    modport master (output imem_req, imem_addr, input  imem_valid, imem_data);
    modport slave  (input  imem_req, imem_addr, output imem_valid, imem_data);
endinterface

// File: rtl/r_seq_ctrl_func_dec.sv
// Combinational R-type decoder: {OP, func} -> {alu_op, legal, nop}.
//   op_i, func_i : instruction fields [31:26] and [5:0]
//   alu_op_o     : ALU opcode (000 when not legal)
//   legal_o      : OP is R-type and func is one of the supported codes
//   nop_o        : OP and func both zero; the caller must still confirm
//                  the remaining instruction bits are zero for a true NOP
module r_func_dec
    import r_seq_ctrl_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] func_i,
    output logic [2:0] alu_op_o,
    output logic       legal_o,
    output logic       nop_o
);

    always_comb begin
        alu_op_o = ALU_AND;
        legal_o  = 1'b0;
        nop_o    = (op_i == OP_RTYPE) && (func_i == 6'b000000);
        if (op_i == OP_RTYPE) begin
            legal_o = 1'b1;
            case (func_i)
                FN_ADD:  alu_op_o = ALU_ADD;
                FN_SUB:  alu_op_o = ALU_SUB;
                FN_AND:  alu_op_o = ALU_AND;
                FN_OR:   alu_op_o = ALU_OR;
                FN_XOR:  alu_op_o = ALU_XOR;
                FN_NOR:  alu_op_o = ALU_NOR;
                FN_SLTU: alu_op_o = ALU_SLTU;
                FN_SLLV: alu_op_o = ALU_SLLV;
                default: legal_o  = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/r_seq_ctrl.sv
// Multi-cycle sequencer for the R-type datapath (register file + ALU).
// Fetches over the imem bus, decodes, steps READ/EXEC/WB and advances PC.
// Traps on illegal instructions and on fetch timeout.
// Ports:
//   clk, rst_n      : clock, async active-low reset
//   run_i           : level, keep executing; 0 stops at instruction boundary
//   trap_clr_i      : pulse, leave TRAP
//   imem            : fetch bus (master modport)
//   rf_ra1/ra2/wa_o : rs / rt / rd register addresses
//   op_ld_o         : pulse in READ, datapath latches operands
//   alu_op_o        : ALU opcode
//   res_ld_o        : pulse in EXEC, datapath latches ALU result
//   rf_we_o         : pulse in WB when rd != 0
//   pc_o            : current PC
//   busy_o, trap_o  : status
//   trap_cause_o    : 00 none, 01 illegal, 10 fetch timeout
//   retired_o       : completed-instruction count (wraps)
module r_seq_ctrl
    import r_seq_ctrl_pkg::*;
#(
    parameter int              PC_W      = 32,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter int              FETCH_TMO = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run_i,
    input  logic              trap_clr_i,
    r_seq_ctrl_if.master      imem,
    output logic [4:0]        rf_ra1_o,
    output logic [4:0]        rf_ra2_o,
    output logic [4:0]        rf_wa_o,
    output logic              op_ld_o,
    output logic [2:0]        alu_op_o,
    output logic              res_ld_o,
    output logic              rf_we_o,
    output logic [PC_W-1:0]   pc_o,
    output logic              busy_o,
    output logic              trap_o,
    output logic [1:0]        trap_cause_o,
    output logic [15:0]       retired_o
);

    localparam int              TMO_W   = (FETCH_TMO < 1) ? 1 : $clog2(FETCH_TMO + 1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(FETCH_TMO);

    state_e            state_q;
    logic [31:0]       ir_q;
    logic [TMO_W-1:0]  tmo_q;
    logic [PC_W-1:0]   pc_q;
    logic [15:0]       ret_q;
    logic              req_q;
    logic              op_ld_q, res_ld_q, rf_we_q;
    logic [4:0]        ra1_q, ra2_q, wa_q;
    logic [2:0]        alu_q;
    logic [1:0]        cause_q;

    logic [PC_W-1:0]   pc_d;
    logic [2:0]        dec_alu;
    logic              dec_legal, dec_nop, is_nop;

    r_func_dec u_dec (
        .op_i     (ir_q[31:26]),
        .func_i   (ir_q[5:0]),
        .alu_op_o (dec_alu),
        .legal_o  (dec_legal),
        .nop_o    (dec_nop)
    );

    // Only the all-zero word is a NOP; op/func zero with other bits set is illegal.
    assign is_nop = dec_nop && (ir_q[25:6] == '0);
    assign pc_d   = pc_q + PC_W'(4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ir_q     <= '0;
            tmo_q    <= '0;
            pc_q     <= RESET_PC;
            ret_q    <= '0;
            req_q    <= 1'b0;
            op_ld_q  <= 1'b0;
            res_ld_q <= 1'b0;
            rf_we_q  <= 1'b0;
            ra1_q    <= '0;
            ra2_q    <= '0;
            wa_q     <= '0;
            alu_q    <= ALU_AND;
            cause_q  <= CAUSE_NONE;
        end else begin
            // Pulse outputs are set on entry to their state and drop after one cycle.
            op_ld_q  <= 1'b0;
            res_ld_q <= 1'b0;
            rf_we_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (run_i) begin
                        state_q <= ST_FETCH;
                        req_q   <= 1'b1;
                        tmo_q   <= '0;
                    end
                end
                ST_FETCH: begin
                    if (imem.imem_valid) begin
                        ir_q    <= imem.imem_data;
                        req_q   <= 1'b0;
                        state_q <= ST_DECODE;
                    end else if (tmo_q == TMO_MAX) begin
                        req_q   <= 1'b0;
                        cause_q <= CAUSE_FTMO;
                        state_q <= ST_TRAP;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                ST_DECODE: begin
                    if (is_nop) begin
                        state_q <= ST_NEXT;
                    end else if (!dec_legal) begin
                        cause_q <= CAUSE_ILLEGAL;
                        state_q <= ST_TRAP;
                    end else begin
                        // Register-file addresses and opcode stay put READ..WB.
                        ra1_q   <= ir_q[25:21];
                        ra2_q   <= ir_q[20:16];
                        wa_q    <= ir_q[15:11];
                        alu_q   <= dec_alu;
                        op_ld_q <= 1'b1;
                        state_q <= ST_READ;
                    end
                end
                ST_READ: begin
                    res_ld_q <= 1'b1;
                    state_q  <= ST_EXEC;
                end
                ST_EXEC: begin
                    rf_we_q <= (wa_q != 5'd0);
                    state_q <= ST_WB;
                end
                // WB also closes the instruction (PC advance, retire, run check)
                // so an ALU instruction is FETCH/DECODE/READ/EXEC/WB = 5 cycles;
                // NEXT does the same for a NOP straight out of DECODE.
                ST_WB, ST_NEXT: begin
                    pc_q  <= pc_d;
                    ret_q <= ret_q + 16'd1;
                    if (run_i) begin
                        state_q <= ST_FETCH;
                        req_q   <= 1'b1;
                        tmo_q   <= '0;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_TRAP: begin
                    if (trap_clr_i) begin
                        cause_q <= CAUSE_NONE;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_q;
    assign rf_ra1_o       = ra1_q;
    assign rf_ra2_o       = ra2_q;
    assign rf_wa_o        = wa_q;
    assign alu_op_o       = alu_q;
    assign op_ld_o        = op_ld_q;
    assign res_ld_o       = res_ld_q;
    assign rf_we_o        = rf_we_q;
    assign pc_o           = pc_q;
    assign retired_o      = ret_q;
    assign trap_cause_o   = cause_q;
    assign busy_o         = !(state_q inside {ST_IDLE, ST_TRAP});
    assign trap_o         = (state_q == ST_TRAP);

endmodule
